morty_lsu: RTL and testbench

MORTY_LSU -- requirements
Module: morty_lsu

---
 rtl/morty_lsu_pkg.sv | 39 +++
 rtl/morty_load_align.sv | 27 ++
 rtl/morty_lsu.sv | 163 ++++++++++++++++
 tb/tb_morty_lsu.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morty_lsu_pkg.sv
// rtl/morty_lsu_pkg.sv - shared LSU definitions: flag positions, exception codes, state and size encodings
package morty_lsu_pkg;

    localparam int FLAG_BYTE     = 0;
    localparam int FLAG_HALF     = 1;
    localparam int FLAG_WORD     = 2;
    localparam int FLAG_UNSIGNED = 3;
    localparam int FLAG_READ     = 4;
    localparam int FLAG_WRITE    = 5;

    localparam logic [3:0] EXC_NONE           = 4'd0;
    localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] EXC_LOAD_FAULT     = 4'd5;
    localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_STORE_FAULT    = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // Collapse the one-hot size flags into an encoded size; word is the fallback.
    function automatic size_e decode_size(input logic [5:0] flags);
        if (flags[FLAG_BYTE]) begin
            return SZ_BYTE;
        end else if (flags[FLAG_HALF]) begin
            return SZ_HALF;
        end
        return SZ_WORD;
    endfunction

endpackage

// File: rtl/morty_load_align.sv
// rtl/morty_load_align.sv - extracts the addressed lane of a read word and sign/zero-extends it
module morty_load_align
    import morty_lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  size_e       size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Pick the byte/half lane, then extend with either the lane MSB or zero.
    always_comb begin
        lane_b = word[{addr, 3'b000} +: 8];
        lane_h = addr[1] ? word[31:16] : word[15:0];
        result = word;
        case (size)
            SZ_BYTE: result = {{24{~is_unsigned & lane_b[7]}}, lane_b};
            SZ_HALF: result = {{16{~is_unsigned & lane_h[15]}}, lane_h};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/morty_lsu.sv
// rtl/morty_lsu.sv - MEM-stage load/store unit driving a Wishbone classic data port
module morty_lsu
    import morty_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_result,
    input  logic [31:0] mem_store_data,
    input  logic [5:0]  mem_mem_flags,
    input  logic        mem_kill,
    output logic [31:0] dport_address,
    output logic [31:0] dport_data_o,
    output logic [3:0]  dport_sel,
    output logic        dport_we,
    output logic        dport_cyc,
    output logic        dport_stb,
    input  logic [31:0] dport_data_i,
    input  logic        dport_ack,
    input  logic        dport_err,
    output logic [31:0] lsu_load_data,
    output logic        lsu_stall,
    output logic [3:0]  lsu_exception,
    output logic [31:0] lsu_exc_data,
    output logic        lsu_exc_valid
);

    lsu_state_e  state;
    logic [31:0] r_addr;
    size_e       r_size;
    logic        r_unsigned;
    logic        r_read;
    logic        drop;
    logic        err_valid;
    logic [3:0]  err_code;

    logic        is_read;
    logic        is_write;
    logic        access_valid;
    logic        misaligned;
    logic        issue;
    logic        mis_exc;
    size_e       size;
    logic [31:0] store_lanes;
    logic [3:0]  store_sel;
    logic [31:0] aligned;

    assign is_read      = mem_mem_flags[FLAG_READ];
    assign is_write     = mem_mem_flags[FLAG_WRITE];
    assign size         = decode_size(mem_mem_flags);
    assign access_valid = (is_read ^ is_write) && $onehot(mem_mem_flags[FLAG_WORD:FLAG_BYTE]);
    assign misaligned   = (mem_mem_flags[FLAG_HALF] && mem_result[0])
                        || (mem_mem_flags[FLAG_WORD] && (mem_result[1:0] != 2'b00));

    // Reset masks both the issue request and the misalignment report.
    assign issue   = !rst && (state == ST_IDLE) && access_valid && !misaligned && !mem_kill;
    assign mis_exc = !rst && (state == ST_IDLE) && access_valid && misaligned && !mem_kill;

    // Replicate store data across the lanes and build the matching byte enables.
    always_comb begin
        store_lanes = mem_store_data;
        store_sel   = 4'b1111;
        case (size)
            SZ_BYTE: begin
                store_lanes = {4{mem_store_data[7:0]}};
                store_sel   = 4'b0001 << mem_result[1:0];
            end
            SZ_HALF: begin
                store_lanes = {2{mem_store_data[15:0]}};
                store_sel   = 4'b0011 << {mem_result[1], 1'b0};
            end
            default: begin
                store_lanes = mem_store_data;
                store_sel   = 4'b1111;
            end
        endcase
    end

    morty_load_align u_align (
        .word        (dport_data_i),
        .addr        (r_addr[1:0]),
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .result      (aligned)
    );

    // Access FSM: latch the bus request on issue, hold it through BUSY, report in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            r_addr        <= 32'd0;
            r_size        <= SZ_BYTE;
            r_unsigned    <= 1'b0;
            r_read        <= 1'b0;
            drop          <= 1'b0;
            dport_data_o  <= 32'd0;
            dport_sel     <= 4'd0;
            dport_we      <= 1'b0;
            dport_cyc     <= 1'b0;
            dport_stb     <= 1'b0;
            lsu_load_data <= 32'd0;
            err_valid     <= 1'b0;
            err_code      <= EXC_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        state        <= ST_BUSY;
                        r_addr       <= mem_result;
                        r_size       <= size;
                        r_unsigned   <= mem_mem_flags[FLAG_UNSIGNED];
                        r_read       <= is_read;
                        drop         <= 1'b0;
                        dport_data_o <= store_lanes;
                        dport_sel    <= store_sel;
                        dport_we     <= is_write;
                        dport_cyc    <= 1'b1;
                        dport_stb    <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (mem_kill) begin
                        drop <= 1'b1;
                    end
                    if (dport_ack || dport_err) begin
                        dport_cyc <= 1'b0;
                        dport_stb <= 1'b0;
                        dport_we  <= 1'b0;
                        drop      <= 1'b0;
                        if (drop || mem_kill) begin
                            // Squashed instruction: let the bus finish, report nothing.
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_DONE;
                            if (dport_err) begin
                                err_valid <= 1'b1;
                                err_code  <= r_read ? EXC_LOAD_FAULT : EXC_STORE_FAULT;
                            end else if (r_read) begin
                                lsu_load_data <= aligned;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    err_valid <= 1'b0;
                    err_code  <= EXC_NONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign dport_address = {r_addr[31:2], 2'b00};
    assign lsu_stall     = issue || (state == ST_BUSY);
    assign lsu_exc_valid = mis_exc || err_valid;
    assign lsu_exception = mis_exc   ? (is_read ? EXC_LOAD_MISALIGN : EXC_STORE_MISALIGN)
                         : err_valid ? err_code
                         : EXC_NONE;
    assign lsu_exc_data  = mis_exc   ? mem_result
                         : err_valid ? r_addr
                         : 32'd0;

endmodule

// File: tb/tb_morty_lsu.sv
// tb/tb_morty_lsu.sv - self-checking bench for morty_lsu
module tb_morty_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_result;
    logic [31:0] mem_store_data;
    logic [5:0]  mem_mem_flags;
    logic        mem_kill;
    logic [31:0] dport_address;
    logic [31:0] dport_data_o;
    logic [3:0]  dport_sel;
    logic        dport_we;
    logic        dport_cyc;
    logic        dport_stb;
    logic [31:0] dport_data_i;
    logic        dport_ack;
    logic        dport_err;
    logic [31:0] lsu_load_data;
    logic        lsu_stall;
    logic [3:0]  lsu_exception;
    logic [31:0] lsu_exc_data;
    logic        lsu_exc_valid;

    morty_lsu dut (
        .clk            (clk),
        .rst            (rst),
        .mem_result     (mem_result),
        .mem_store_data (mem_store_data),
        .mem_mem_flags  (mem_mem_flags),
        .mem_kill       (mem_kill),
        .dport_address  (dport_address),
        .dport_data_o   (dport_data_o),
        .dport_sel      (dport_sel),
        .dport_we       (dport_we),
        .dport_cyc      (dport_cyc),
        .dport_stb      (dport_stb),
        .dport_data_i   (dport_data_i),
        .dport_ack      (dport_ack),
        .dport_err      (dport_err),
        .lsu_load_data  (lsu_load_data),
        .lsu_stall      (lsu_stall),
        .lsu_exception  (lsu_exception),
        .lsu_exc_data   (lsu_exc_data),
        .lsu_exc_valid  (lsu_exc_valid)
    );

    always #5 clk = ~clk;

    typedef enum int {K_BUS, K_MIS, K_NONE} kind_e;

    typedef struct {
        kind_e       kind;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [5:0]  flags;
        logic [31:0] rdata;
        int          delay;
        logic        err;
        logic [31:0] e_addr;
        logic [31:0] e_dout;
        logic [3:0]  e_sel;
        logic        e_we;
        logic [31:0] e_load;
        logic        e_xv;
        logic [3:0]  e_code;
        logic [31:0] e_xdata;
    } vec_t;

    typedef struct {
        logic [31:0] load;
        logic        xv;
        logic [3:0]  code;
        logic [31:0] xdata;
    } res_t;

    vec_t vecs[$];
    res_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        res_t r;
        if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: scoreboard empty, got result with nothing expected", tag);
            return;
        end
        r = sb.pop_front();
        chk({tag, "_exc_valid"}, lsu_exc_valid, r.xv);
        chk({tag, "_exc_code"}, lsu_exception, r.code);
        if (r.xv) chk({tag, "_exc_data"}, lsu_exc_data, r.xdata);
        chk({tag, "_load_data"}, lsu_load_data, r.load);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        int    stalls;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        mem_result     = v.addr;
        mem_store_data = v.sdata;
        mem_mem_flags  = v.flags;
        mem_kill       = 1'b0;
        dport_ack      = 1'b0;
        dport_err      = 1'b0;
        dport_data_i   = v.rdata;
        sb.push_back(res_t'{v.e_load, v.e_xv, v.e_code, v.e_xdata});
        #1;
        if (v.kind != K_BUS) begin
            chk({tag, "_stall"}, lsu_stall, 1'b0);
            pop_check(tag);
            @(negedge clk);
            #1;
            chk({tag, "_no_cyc"}, dport_cyc, 1'b0);
            mem_mem_flags = 6'd0;
        end else begin
            stalls = 0;
            chk({tag, "_stall_issue"}, lsu_stall, 1'b1);
            if (lsu_stall) stalls++;
            @(negedge clk);
            chk({tag, "_cyc"}, dport_cyc, 1'b1);
            chk({tag, "_stb"}, dport_stb, 1'b1);
            chk({tag, "_we"}, dport_we, v.e_we);
            chk({tag, "_sel"}, dport_sel, v.e_sel);
            chk({tag, "_addr"}, dport_address, v.e_addr);
            chk({tag, "_dout"}, dport_data_o, v.e_dout);
            for (int i = 0; i < v.delay; i++) begin
                if (lsu_stall) stalls++;
                @(negedge clk);
            end
            if (lsu_stall) stalls++;
            chk({tag, "_held_cyc"}, dport_cyc, 1'b1);
            chk({tag, "_held_dout"}, dport_data_o, v.e_dout);
            dport_ack = 1'b1;
            dport_err = v.err;
            @(negedge clk);
            dport_ack = 1'b0;
            dport_err = 1'b0;
            #1;
            chk({tag, "_done_stall"}, lsu_stall, 1'b0);
            chk({tag, "_done_cyc"}, dport_cyc, 1'b0);
            chk({tag, "_stall_cycles"}, stalls, 2 + v.delay);
            pop_check(tag);
            mem_mem_flags = 6'd0;
            @(negedge clk);
            #1;
            chk({tag, "_idle_exc"}, lsu_exc_valid, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        mem_result     = 32'h105;
        mem_store_data = 32'd0;
        mem_mem_flags  = 6'h14;
        mem_kill       = 1'b0;
        dport_data_i   = 32'd0;
        dport_ack      = 1'b0;
        dport_err      = 1'b0;

        //                kind    addr     sdata         flags  rdata         dly err  e_addr   e_dout        sel      we  e_load        xv code  xdata
        vecs.push_back(vec_t'{K_BUS,  32'h103, 32'h0,        6'h11, 32'h80FF1234, 0, 0, 32'h100, 32'h0,        4'b1000, 0, 32'hFFFFFF80, 0, 4'd0, 32'h0});
        vecs.push_back(vec_t'{K_BUS,  32'h202, 32'hDEADBEEF, 6'h22, 32'h0,        1, 0, 32'h200, 32'hBEEFBEEF, 4'b1100, 1, 32'hFFFFFF80, 0, 4'd0, 32'h0});
        vecs.push_back(vec_t'{K_BUS,  32'h101, 32'h0,        6'h19, 32'h1234F0A5, 0, 0, 32'h100, 32'h0,        4'b0010, 0, 32'h000000F0, 0, 4'd0, 32'h0});
        vecs.push_back(vec_t'{K_BUS,  32'h042, 32'h0,        6'h12, 32'h80017FFF, 0, 0, 32'h040, 32'h0,        4'b1100, 0, 32'hFFFF8001, 0, 4'd0, 32'h0});
        vecs.push_back(vec_t'{K_BUS,  32'h040, 32'h0,        6'h1A, 32'h8001F00D, 1, 0, 32'h040, 32'h0,        4'b0011, 0, 32'h0000F00D, 0, 4'd0, 32'h0});
        vecs.push_back(vec_t'{K_BUS,  32'h300, 32'h0,        6'h14, 32'hCAFEBABE, 2, 0, 32'h300, 32'h0,        4'b1111, 0, 32'hCAFEBABE, 0, 4'd0, 32'h0});
        vecs.push_back(vec_t'{K_BUS,  32'h011, 32'h123456A7, 6'h21, 32'h0,        0, 0, 32'h010, 32'hA7A7A7A7, 4'b0010, 1, 32'hCAFEBABE, 0, 4'd0, 32'h0});
        vecs.push_back(vec_t'{K_BUS,  32'h020, 32'h0BADF00D, 6'h24, 32'h0,        0, 0, 32'h020, 32'h0BADF00D, 4'b1111, 1, 32'hCAFEBABE, 0, 4'd0, 32'h0});
        vecs.push_back(vec_t'{K_MIS,  32'h105, 32'h0,        6'h14, 32'h0,        0, 0, 32'h0,   32'h0,        4'b0000, 0, 32'hCAFEBABE, 1, 4'd4, 32'h105});
        vecs.push_back(vec_t'{K_MIS,  32'h203, 32'h1,        6'h22, 32'h0,        0, 0, 32'h0,   32'h0,        4'b0000, 0, 32'hCAFEBABE, 1, 4'd6, 32'h203});
        vecs.push_back(vec_t'{K_MIS,  32'h001, 32'h0,        6'h12, 32'h0,        0, 0, 32'h0,   32'h0,        4'b0000, 0, 32'hCAFEBABE, 1, 4'd4, 32'h001});
        vecs.push_back(vec_t'{K_MIS,  32'h106, 32'h0,        6'h24, 32'h0,        0, 0, 32'h0,   32'h0,        4'b0000, 0, 32'hCAFEBABE, 1, 4'd6, 32'h106});
        vecs.push_back(vec_t'{K_NONE, 32'h100, 32'h0,        6'h31, 32'h0,        0, 0, 32'h0,   32'h0,        4'b0000, 0, 32'hCAFEBABE, 0, 4'd0, 32'h0});
        vecs.push_back(vec_t'{K_NONE, 32'h100, 32'h0,        6'h13, 32'h0,        0, 0, 32'h0,   32'h0,        4'b0000, 0, 32'hCAFEBABE, 0, 4'd0, 32'h0});
        vecs.push_back(vec_t'{K_NONE, 32'h100, 32'h0,        6'h10, 32'h0,        0, 0, 32'h0,   32'h0,        4'b0000, 0, 32'hCAFEBABE, 0, 4'd0, 32'h0});
        vecs.push_back(vec_t'{K_NONE, 32'h100, 32'h0,        6'h04, 32'h0,        0, 0, 32'h0,   32'h0,        4'b0000, 0, 32'hCAFEBABE, 0, 4'd0, 32'h0});
        vecs.push_back(vec_t'{K_BUS,  32'h400, 32'h11223344, 6'h24, 32'h0,        0, 1, 32'h400, 32'h11223344, 4'b1111, 1, 32'hCAFEBABE, 1, 4'd7, 32'h400});
        vecs.push_back(vec_t'{K_BUS,  32'h500, 32'h0,        6'h14, 32'hDEADDEAD, 1, 1, 32'h500, 32'h0,        4'b1111, 0, 32'hCAFEBABE, 1, 4'd5, 32'h500});
        vecs.push_back(vec_t'{K_BUS,  32'h7FC, 32'h0,        6'h14, 32'h00000001, 0, 0, 32'h7FC, 32'h0,        4'b1111, 0, 32'h00000001, 0, 4'd0, 32'h0});

        // Reset with a misaligned access presented: nothing may be reported.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_exc_valid", lsu_exc_valid, 1'b0);
        chk("rst_exc_code", lsu_exception, 4'd0);
        chk("rst_cyc", dport_cyc, 1'b0);
        rst           = 1'b0;
        mem_mem_flags = 6'd0;
        #1;
        chk("rst_stall", lsu_stall, 1'b0);
        chk("rst_load", lsu_load_data, 32'd0);
        chk("rst_addr", dport_address, 32'd0);
        chk("rst_sel", dport_sel, 4'd0);
        chk("rst_dout", dport_data_o, 32'd0);
        chk("rst_we", dport_we, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        // Kill while idle: neither an issue nor a misalignment report.
        @(negedge clk);
        mem_result = 32'h080; mem_mem_flags = 6'h14; mem_kill = 1'b1;
        #1;
        chk("kill_idle_stall", lsu_stall, 1'b0);
        @(negedge clk);
        #1;
        chk("kill_idle_cyc", dport_cyc, 1'b0);
        mem_result = 32'h105;
        #1;
        chk("kill_idle_mis_exc", lsu_exc_valid, 1'b0);
        chk("kill_idle_mis_code", lsu_exception, 4'd0);
        mem_kill = 1'b0; mem_mem_flags = 6'd0;

        // Kill during BUSY: bus cycle completes, result and exception are dropped.
        @(negedge clk);
        mem_result = 32'h060; mem_mem_flags = 6'h1A; dport_data_i = 32'h00001111;
        #1;
        chk("kbusy_issue_stall", lsu_stall, 1'b1);
        @(negedge clk);
        mem_kill = 1'b1;
        #1;
        chk("kbusy_cyc", dport_cyc, 1'b1);
        chk("kbusy_stall", lsu_stall, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mem_kill = 1'b0;
            #1;
            chk("kbusy_wait_cyc", dport_cyc, 1'b1);
            chk("kbusy_wait_stall", lsu_stall, 1'b1);
        end
        @(negedge clk);
        dport_ack = 1'b1; mem_mem_flags = 6'd0;
        @(negedge clk);
        dport_ack = 1'b0;
        #1;
        chk("kbusy_end_cyc", dport_cyc, 1'b0);
        chk("kbusy_end_stall", lsu_stall, 1'b0);
        chk("kbusy_end_exc", lsu_exc_valid, 1'b0);
        chk("kbusy_end_code", lsu_exception, 4'd0);
        chk("kbusy_end_load", lsu_load_data, 32'h00000001);
        // A fresh access issues immediately, which only happens from IDLE.
        mem_result = 32'h7FC; mem_mem_flags = 6'h14; dport_data_i = 32'h00000002;
        #1;
        chk("kbusy_reissue_stall", lsu_stall, 1'b1);
        @(negedge clk);
        chk("kbusy_reissue_cyc", dport_cyc, 1'b1);
        dport_ack = 1'b1;
        @(negedge clk);
        dport_ack = 1'b0; mem_mem_flags = 6'd0;
        #1;
        chk("kbusy_reissue_load", lsu_load_data, 32'h00000002);

        // Reset mid-BUSY with a late ack afterwards.
        @(negedge clk);
        mem_result = 32'h700; mem_store_data = 32'h55AA55AA; mem_mem_flags = 6'h24;
        #1;
        chk("rbusy_issue_stall", lsu_stall, 1'b1);
        @(negedge clk);
        chk("rbusy_cyc", dport_cyc, 1'b1);
        rst = 1'b1; mem_mem_flags = 6'd0;
        @(negedge clk);
        rst = 1'b0; dport_ack = 1'b1; dport_data_i = 32'hFFFFFFFF;
        #1;
        chk("rbusy_cyc_after", dport_cyc, 1'b0);
        chk("rbusy_stb_after", dport_stb, 1'b0);
        chk("rbusy_we_after", dport_we, 1'b0);
        chk("rbusy_sel_after", dport_sel, 4'd0);
        chk("rbusy_addr_after", dport_address, 32'd0);
        chk("rbusy_dout_after", dport_data_o, 32'd0);
        chk("rbusy_load_after", lsu_load_data, 32'd0);
        chk("rbusy_stall_after", lsu_stall, 1'b0);
        @(negedge clk);
        dport_ack = 1'b0;
        #1;
        chk("rbusy_late_ack_cyc", dport_cyc, 1'b0);
        chk("rbusy_late_ack_exc", lsu_exc_valid, 1'b0);
        chk("rbusy_late_ack_code", lsu_exception, 4'd0);
        chk("rbusy_late_ack_load", lsu_load_data, 32'd0);
        chk("rbusy_late_ack_stall", lsu_stall, 1'b0);

        if (sb.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL scoreboard_leftover: got %0d pending expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
